// File: rtl/xm23_pipe_regfile_pkg.sv
// Shared defaults, decode-bundle type and the fixed constant table for the XM23 pipeline block.
package xm23_pipe_regfile_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned NUM_REGS_DEF   = 8;
  localparam int unsigned NUM_STAGES_DEF = 3;
  localparam int unsigned CTRL_W_DEF     = 41;
  localparam int unsigned PSW_W          = 16;

  typedef logic [CTRL_W_DEF-1:0] ctrl_bundle_t;

  // Enable vector occupies the low bits of the bundle; decoded fields sit above it.
  localparam int unsigned EN_BIT_GPR_WR = 0;
  localparam int unsigned EN_BIT_PSW_WR = 1;
  localparam int unsigned EN_BIT_MEM_RD = 2;
  localparam int unsigned EN_BIT_MEM_WR = 3;
  localparam int unsigned EN_BIT_BRANCH = 4;
  localparam int unsigned EN_BIT_INCDEC = 5;

  // Constant table, index 7 is -1 (all ones after truncation to the data width).
  localparam int unsigned CONST_ENTRIES = 8;
  localparam logic [CONST_ENTRIES-1:0][31:0] CONST_TABLE = {
    32'hFFFF_FFFF, 32'd32, 32'd16, 32'd8, 32'd4, 32'd2, 32'd1, 32'd0
  };

  // Indices beyond the table read as zero.
  function automatic logic [31:0] const_lookup(input int unsigned idx);
    logic [2:0] idx3;
    idx3 = idx[2:0];
    if (idx < CONST_ENTRIES) begin
      return CONST_TABLE[idx3];
    end
    return 32'd0;
  endfunction

endpackage

// File: rtl/xm23_pipe_regfile_if.sv
// Decoder/execute-facing bus of the pipeline register and GPR block.
interface xm23_pipe_regfile_if
  import xm23_pipe_regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter int unsigned ADDR_W     = $clog2(NUM_REGS)
);

  logic                         in_valid;
  logic [CTRL_W-1:0]            in_ctrl;
  logic                         stall_in;
  logic [NUM_STAGES-1:0]        flush_in;
  logic [NUM_STAGES-1:0]        stg_valid_o;
  logic [NUM_STAGES*CTRL_W-1:0] stg_ctrl_o;

  logic                         wa_en;
  logic [ADDR_W-1:0]            wa_addr;
  logic [DATA_W-1:0]            wa_data;
  logic                         wb_en;
  logic [ADDR_W-1:0]            wb_addr;
  logic [DATA_W-1:0]            wb_data;

  logic [ADDR_W-1:0]            ra_addr;
  logic [ADDR_W-1:0]            rb_addr;
  logic                         ra_rc;
  logic                         rb_rc;
  logic [DATA_W-1:0]            ra_data;
  logic [DATA_W-1:0]            rb_data;

  logic [PSW_W-1:0]             psw_mask;
  logic [PSW_W-1:0]             psw_in;
  logic                         psw_ckpt;
  logic                         psw_restore;
  logic [PSW_W-1:0]             psw_o;

  logic [NUM_REGS*DATA_W-1:0]   gpr_o;

  modport master (
    output in_valid, in_ctrl, stall_in, flush_in,
    output wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    output ra_addr, rb_addr, ra_rc, rb_rc,
    output psw_mask, psw_in, psw_ckpt, psw_restore,
    input  stg_valid_o, stg_ctrl_o, ra_data, rb_data, psw_o, gpr_o
  );

  modport slave (
    input  in_valid, in_ctrl, stall_in, flush_in,
    input  wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    input  ra_addr, rb_addr, ra_rc, rb_rc,
    input  psw_mask, psw_in, psw_ckpt, psw_restore,
    output stg_valid_o, stg_ctrl_o, ra_data, rb_data, psw_o, gpr_o
  );

endinterface

// File: rtl/xm23_pipe_regfile_gpr.sv
// GPR array with two write ports (A wins on collision) and two forwarding read ports
// that can alternatively select the fixed constant table.
module xm23_pipe_regfile_gpr
  import xm23_pipe_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_gprc,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [ADDR_W-1:0]          ra_addr,
  input  logic                       ra_rc,
  input  logic [ADDR_W-1:0]          rb_addr,
  input  logic                       rb_rc,
  output logic [DATA_W-1:0]          ra_data,
  output logic [DATA_W-1:0]          rb_data,
  output logic [NUM_REGS*DATA_W-1:0] gpr_flat
);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];

  logic wb_keep;
  assign wb_keep = wb_en && !(wa_en && (wa_addr == wb_addr));

  // Register file update; port B is dropped when it targets the same register as port A.
  always_ff @(posedge clk or posedge reset_gprc) begin
    if (reset_gprc) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      if (wb_keep) begin
        gpr_q[wb_addr] <= wb_data;
      end
      if (wa_en) begin
        gpr_q[wa_addr] <= wa_data;
      end
    end
  end

  // Forwarding order mirrors write priority so a read never sees a value that will be dropped.
  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] addr,
                                                 input logic              rc,
                                                 input logic [DATA_W-1:0] stored);
    if (rc) begin
      return DATA_W'(const_lookup(32'(addr)));
    end else if (wa_en && (wa_addr == addr)) begin
      return wa_data;
    end else if (wb_en && (wb_addr == addr)) begin
      return wb_data;
    end
    return stored;
  endfunction

  // Combinational read ports.
  always_comb begin
    ra_data = read_mux(ra_addr, ra_rc, gpr_q[ra_addr]);
    rb_data = read_mux(rb_addr, rb_rc, gpr_q[rb_addr]);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign gpr_flat[g*DATA_W +: DATA_W] = gpr_q[g];
  end

endmodule

// File: rtl/xm23_pipe_regfile.sv
// XM23 pipeline register / GPR block: decode-bundle shift pipeline with per-stage valid and
// flush, the GPR file with constant table, and the PSW with a single checkpoint.
module xm23_pipe_regfile
  import xm23_pipe_regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF
) (
  input logic                clk,
  input logic                reset_gprc,
  xm23_pipe_regfile_if.slave bus
);

  logic [CTRL_W-1:0]     ctrl_q [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [PSW_W-1:0]      psw_q;
  logic [PSW_W-1:0]      psw_d;
  logic [PSW_W-1:0]      ckpt_q;

  // Next valid per stage: flush beats stall beats load.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = bus.in_valid & ~bus.stall_in & ~bus.flush_in[0];
    for (int k = 1; k < NUM_STAGES; k++) begin
      valid_d[k] = valid_q[k-1] & ~bus.flush_in[k];
    end
  end

  // Stage registers; a stage that ends up invalid keeps its previous bundle.
  always_ff @(posedge clk or posedge reset_gprc) begin
    if (reset_gprc) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        ctrl_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (valid_d[0]) begin
        ctrl_q[0] <= bus.in_ctrl;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (valid_d[k]) begin
          ctrl_q[k] <= ctrl_q[k-1];
        end
      end
    end
  end

  assign bus.stg_valid_o = valid_q;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stg
    assign bus.stg_ctrl_o[g*CTRL_W +: CTRL_W] = ctrl_q[g];
  end

  // Restore from the checkpoint overrides any masked update in the same cycle.
  always_comb begin
    psw_d = (psw_q & ~bus.psw_mask) | (bus.psw_in & bus.psw_mask);
    if (bus.psw_restore) begin
      psw_d = ckpt_q;
    end
  end

  // PSW and checkpoint; the checkpoint always captures the pre-edge PSW.
  always_ff @(posedge clk or posedge reset_gprc) begin
    if (reset_gprc) begin
      psw_q  <= '0;
      ckpt_q <= '0;
    end else begin
      psw_q <= psw_d;
      if (bus.psw_ckpt) begin
        ckpt_q <= psw_q;
      end
    end
  end

  assign bus.psw_o = psw_q;

  xm23_pipe_regfile_gpr #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_gpr (
    .clk        (clk),
    .reset_gprc (reset_gprc),
    .wa_en      (bus.wa_en),
    .wa_addr    (bus.wa_addr),
    .wa_data    (bus.wa_data),
    .wb_en      (bus.wb_en),
    .wb_addr    (bus.wb_addr),
    .wb_data    (bus.wb_data),
    .ra_addr    (bus.ra_addr),
    .ra_rc      (bus.ra_rc),
    .rb_addr    (bus.rb_addr),
    .rb_rc      (bus.rb_rc),
    .ra_data    (bus.ra_data),
    .rb_data    (bus.rb_data),
    .gpr_flat   (bus.gpr_o)
  );

endmodule

// File: tb/tb_xm23_pipe_regfile.sv
// Scoreboard bench for xm23_pipe_regfile: the driver queues expected observations, a negedge
// monitor pops and compares them against the DUT.
module tb_xm23_pipe_regfile;

  localparam int CW = 41;
  localparam int DW = 16;

  typedef enum int {SelRa, SelRb, SelPsw, SelGpr, SelGprAll, SelValid, SelCtrlAll} sel_e;

  typedef struct {
    int           due;
    sel_e         sel;
    int           idx;
    logic [127:0] exp;
    string        name;
  } chk_t;

  typedef struct {
    int          stage;
    int          due;
    logic [CW-1:0] ctrl;
  } pipe_t;

  chk_t  chk_q[$];
  pipe_t pipe_q[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;
  int    c;

  logic clk = 1'b0;
  logic reset_gprc;

  xm23_pipe_regfile_if bus ();

  xm23_pipe_regfile dut (
    .clk        (clk),
    .reset_gprc (reset_gprc),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] actual(input sel_e sel, input int idx);
    case (sel)
      SelRa:      return 128'(bus.ra_data);
      SelRb:      return 128'(bus.rb_data);
      SelPsw:     return 128'(bus.psw_o);
      SelGpr:     return 128'(bus.gpr_o[idx*DW +: DW]);
      SelGprAll:  return 128'(bus.gpr_o);
      SelValid:   return 128'(bus.stg_valid_o);
      SelCtrlAll: return 128'(bus.stg_ctrl_o);
      default:    return '0;
    endcase
  endfunction

  // Monitor: scheduled checks plus pipeline-stage scoreboard.
  always @(negedge clk) begin
    logic [127:0] act;
    int found;
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].due <= cyc) begin
        act = actual(chk_q[i].sel, chk_q[i].idx);
        total++;
        if (act !== chk_q[i].exp) begin
          bad++;
          $display("FAIL %s: got %0h want %0h (cycle %0d)", chk_q[i].name, act, chk_q[i].exp,
                   cyc);
        end
        chk_q.delete(i);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (bus.stg_valid_o[k] !== 1'b0) begin
        found = -1;
        for (int i = 0; i < pipe_q.size(); i++) begin
          if (pipe_q[i].stage == k && pipe_q[i].due == cyc) found = i;
        end
        total++;
        if (found < 0) begin
          bad++;
          $display("FAIL stage%0d_unexpected: got valid=%b ctrl=%0h want valid=0 (cycle %0d)",
                   k, bus.stg_valid_o[k], bus.stg_ctrl_o[k*CW +: CW], cyc);
        end else begin
          if (bus.stg_ctrl_o[k*CW +: CW] !== pipe_q[found].ctrl) begin
            bad++;
            $display("FAIL stage%0d_ctrl: got %0h want %0h (cycle %0d)", k,
                     bus.stg_ctrl_o[k*CW +: CW], pipe_q[found].ctrl, cyc);
          end
          pipe_q.delete(found);
        end
      end
    end
    for (int i = pipe_q.size() - 1; i >= 0; i--) begin
      if (pipe_q[i].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL stage%0d_missing: got valid=0 want valid=1 ctrl=%0h (cycle %0d)",
                 pipe_q[i].stage, pipe_q[i].ctrl, cyc);
        pipe_q.delete(i);
      end
    end
  end

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_ctrl     = '0;
    bus.stall_in    = 1'b0;
    bus.flush_in    = '0;
    bus.wa_en       = 1'b0;
    bus.wa_addr     = '0;
    bus.wa_data     = '0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.ra_addr     = '0;
    bus.rb_addr     = '0;
    bus.ra_rc       = 1'b0;
    bus.rb_rc       = 1'b0;
    bus.psw_mask    = '0;
    bus.psw_in      = '0;
    bus.psw_ckpt    = 1'b0;
    bus.psw_restore = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input int due, input sel_e sel, input int idx, input logic [127:0] exp,
                     input string name);
    chk_t t;
    t.due  = due;
    t.sel  = sel;
    t.idx  = idx;
    t.exp  = exp;
    t.name = name;
    chk_q.push_back(t);
  endtask

  // Drive a bundle this cycle and expect it in stages 0..nst-1 from the next cycle on.
  task automatic issue(input logic [CW-1:0] ctrl, input int nst);
    pipe_t p;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = ctrl;
    for (int k = 0; k < nst; k++) begin
      p.stage = k;
      p.due   = cyc + 1 + k;
      p.ctrl  = ctrl;
      pipe_q.push_back(p);
    end
  endtask

  task automatic wr_a(input int addr, input logic [15:0] data);
    bus.wa_en   = 1'b1;
    bus.wa_addr = 3'(addr);
    bus.wa_data = data;
  endtask

  task automatic wr_b(input int addr, input logic [15:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'(addr);
    bus.wb_data = data;
  endtask

  task automatic psw_upd(input logic [15:0] mask, input logic [15:0] val);
    bus.psw_mask = mask;
    bus.psw_in   = val;
  endtask

  initial begin
    reset_gprc = 1'b1;
    idle();

    // Reset state
    tick();
    chk(cyc, SelValid, 0, '0, "rst_valid");
    chk(cyc, SelPsw, 0, '0, "rst_psw");
    chk(cyc, SelGprAll, 0, '0, "rst_gpr");
    chk(cyc, SelCtrlAll, 0, '0, "rst_ctrl");
    tick();
    reset_gprc = 1'b0;

    // Single bundle flows through all three stages
    tick();
    issue(41'h1_2345_6789A, 3);
    repeat (5) tick();

    // Stall: bundle C is never accepted, B keeps advancing
    issue(41'h0_0000_000B1, 3);
    tick();
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 41'h0_0000_000C2;
    bus.stall_in = 1'b1;
    repeat (5) tick();

    // Flush stage 1 only: D dies after stage 0, E loads behind it, F follows
    issue(41'h0_0000_000D3, 1);
    tick();
    issue(41'h0_0000_000E4, 3);
    bus.flush_in = 3'b010;
    tick();
    issue(41'h0_0000_000F5, 3);
    tick();
    // Flush stage 0 with a valid input: G is dropped
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 41'h0_0000_00067;
    bus.flush_in = 3'b001;
    repeat (5) tick();

    // Write collision: port A wins and is forwarded
    wr_a(3, 16'h1111);
    wr_b(3, 16'h2222);
    bus.ra_addr = 3'd3;
    bus.rb_addr = 3'd3;
    chk(cyc, SelRa, 0, 128'(16'h1111), "coll_fwd_a");
    chk(cyc, SelRb, 0, 128'(16'h1111), "coll_fwd_b");
    chk(cyc + 1, SelGpr, 3, 128'(16'h1111), "coll_gpr3");
    tick();

    // Distinct addresses on both ports, both forwarded
    wr_b(5, 16'hBEEF);
    wr_a(6, 16'h6666);
    bus.rb_addr = 3'd5;
    bus.ra_addr = 3'd6;
    chk(cyc, SelRb, 0, 128'(16'hBEEF), "fwd_b_r5");
    chk(cyc, SelRa, 0, 128'(16'h6666), "fwd_a_r6");
    chk(cyc + 1, SelGpr, 5, 128'(16'hBEEF), "gpr_r5");
    chk(cyc + 1, SelGpr, 6, 128'(16'h6666), "gpr_r6");
    tick();

    // Stored reads without forwarding
    bus.rb_addr = 3'd5;
    bus.ra_addr = 3'd3;
    chk(cyc, SelRb, 0, 128'(16'hBEEF), "rd_r5");
    chk(cyc, SelRa, 0, 128'(16'h1111), "rd_r3");
    tick();

    // Constant table ignores forwarding
    bus.ra_rc   = 1'b1;
    bus.ra_addr = 3'd7;
    bus.rb_rc   = 1'b1;
    bus.rb_addr = 3'd4;
    wr_a(7, 16'h7777);
    chk(cyc, SelRa, 0, 128'(16'hFFFF), "const7");
    chk(cyc, SelRb, 0, 128'(16'h0008), "const4");
    tick();
    bus.ra_rc   = 1'b1;
    bus.ra_addr = 3'd5;
    bus.rb_addr = 3'd7;
    chk(cyc, SelRa, 0, 128'(16'h0010), "const5");
    chk(cyc, SelRb, 0, 128'(16'h7777), "rd_r7");
    chk(cyc, SelGprAll, 0, {16'h7777, 16'h6666, 16'hBEEF, 16'h0000, 16'h1111, 16'h0000,
                            16'h0000, 16'h0000}, "gpr_all");
    tick();

    // PSW checkpoint / masked update / restore
    bus.psw_ckpt = 1'b1;
    tick();
    psw_upd(16'h000F, 16'h0005);
    chk(cyc + 1, SelPsw, 0, 128'(16'h0005), "psw_upd5");
    tick();
    bus.psw_restore = 1'b1;
    chk(cyc + 1, SelPsw, 0, 128'(16'h0000), "psw_restore0");
    tick();
    bus.psw_restore = 1'b1;
    psw_upd(16'hFFFF, 16'h1234);
    chk(cyc + 1, SelPsw, 0, 128'(16'h0000), "psw_restore_beats_upd");
    tick();
    psw_upd(16'hFFFF, 16'h00A0);
    chk(cyc + 1, SelPsw, 0, 128'(16'h00A0), "psw_a0");
    tick();
    bus.psw_ckpt = 1'b1;
    psw_upd(16'h00FF, 16'h0033);
    chk(cyc + 1, SelPsw, 0, 128'(16'h0033), "psw_partial_mask");
    tick();
    bus.psw_restore = 1'b1;
    psw_upd(16'hFFFF, 16'h1234);
    chk(cyc + 1, SelPsw, 0, 128'(16'h00A0), "psw_ckpt_pre_update");
    tick();
    psw_upd(16'hFFFF, 16'h5555);
    tick();
    bus.psw_ckpt    = 1'b1;
    bus.psw_restore = 1'b1;
    chk(cyc + 1, SelPsw, 0, 128'(16'h00A0), "psw_ckpt_restore_old");
    tick();
    bus.psw_restore = 1'b1;
    chk(cyc + 1, SelPsw, 0, 128'(16'h5555), "psw_ckpt_took_current");
    tick();

    // Asynchronous reset mid-operation drops the in-flight bundle and pending write
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 41'h0_0000_00099;
    wr_a(1, 16'h0101);
    tick();
    reset_gprc = 1'b1;
    wr_a(2, 16'h0202);
    chk(cyc, SelGprAll, 0, '0, "midrst_gpr");
    chk(cyc, SelPsw, 0, '0, "midrst_psw");
    chk(cyc, SelValid, 0, '0, "midrst_valid");
    chk(cyc, SelCtrlAll, 0, '0, "midrst_ctrl");
    tick();
    reset_gprc = 1'b0;
    tick();
    chk(cyc, SelGprAll, 0, '0, "postrst_gpr");

    // Recovery after reset
    issue(41'h1_5A5A_A5A5_5, 3);
    repeat (6) tick();

    total++;
    if (chk_q.size() != 0 || pipe_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained: got chk=%0d pipe=%0d want 0", chk_q.size(), pipe_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
